efb_wb_arbiter: RTL and testbench
=================================

# efb_wb_arbiter

Two-master Wishbone arbiter that shares the single 8-bit EFB slave port (UFM/flash access) between two requesters, e.g. `ufm_reader` and a second flash client such as a config loader or UART command handler. It holds a grant for a whole `cyc` burst, so a multi-transaction UFM command sequence is never interleaved with the other master's traffic. It includes a per-transfer watchdog that aborts a hung EFB transfer with an error strobe.

## Interface
- `ROUND_ROBIN`, default 1: 1 = round-robin on simultaneous requests; 0 = fixed priority, m0 wins.
- `TIMEOUT_CYCLES`, default 255: maximum cycles a strobed transfer may wait for ack. Range 0..65535; 0 disables the watchdog.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst_n` in 1: synchronous, active-low reset.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i` in 1 each: master 0 Wishbone controls.
- `m0_adr_i` in 8, `m0_dat_i` in 8: master 0 address and write data.
- `m0_dat_o` out 8: read data to master 0.
- `m0_ack_o` out 1, `m0_err_o` out 1: transfer ack and watchdog abort to master 0.
- `m1_*`: same set as m0, for master 1.
- `s_cyc_o`, `s_stb_o`, `s_we_o` out 1 each: controls to the EFB slave.
- `s_adr_o` out 8, `s_dat_o` out 8: address and write data to the EFB slave.
- `s_dat_i` in 8, `s_ack_i` in 1: EFB read data and ack.
- `grant` out 2: one-hot current owner; 00 = none.

## Operation
- States:
  - IDLE: no owner.
  - OWN: owner register valid.
  - ABORT: watchdog fired; waiting for the owner to drop `cyc`.
- IDLE:
  - If any `mX_cyc_i` is high, register the owner, set `grant`, go to OWN.
  - Tie with `ROUND_ROBIN`=1: grant the master that is not `last_owner`.
  - Tie with `ROUND_ROBIN`=0: grant m0.
- OWN:
  - `s_cyc_o`, `s_stb_o`, `s_we_o`, `s_adr_o`, `s_dat_o` combinationally mux the owner's inputs.
  - The owner's `ack_o` equals `s_ack_i`.
  - If the owner's `cyc_i` is low, `s_cyc_o`/`s_stb_o` are forced 0, `last_owner` is updated, and the state goes to IDLE. The grant clears on the next edge.
- Non-owner:
  - `ack_o`/`err_o` held 0.
  - `cyc`/`stb` ignored; the request stays pending.
- `m0_dat_o` and `m1_dat_o` both always carry `s_dat_i` (broadcast). Only the ack qualifies the data.
- Watchdog:
  - 16-bit `wd_cnt` is cleared in IDLE, on `s_ack_i`, and whenever `s_stb_o`=0.
  - Otherwise it increments while `s_stb_o`=1 in OWN.
  - When `wd_cnt` == `TIMEOUT_CYCLES`-1 with no ack in that cycle:
    - pulse the owner's `err_o` for one cycle;
    - drive `s_cyc_o`/`s_stb_o` to 0 from the next cycle;
    - go to ABORT.
- ABORT:
  - Slave outputs are idle; `grant` is held.
  - When the owner's `cyc_i` is low, go to IDLE and update `last_owner`.
- Reset (any time, including mid-transfer), at the same edge:
  - state IDLE, `grant`=00, `last_owner`=m1 (so m0 wins the first tie), `wd_cnt`=0;
  - all `s_*` outputs and all ack/err outputs are 0.

## Timing
- Grant latency: `cyc` rises at edge N (sampled high) → `grant` and slave outputs valid after edge N+1. Worst case is 1 cycle from an idle bus.
- Ack path is combinational: `s_ack_i` → owner's `ack_o` in the same cycle, with zero added latency. Data path is the same.
- Release: owner drops `cyc` in cycle K → IDLE after edge K+1. The other master is granted after edge K+2, giving one dead cycle between owners.
- The grant never changes while the owner holds `cyc`, regardless of the other master's requests or any gaps in `stb`.
- Watchdog (T = `TIMEOUT_CYCLES`): with stb high and no ack, `err_o` is asserted in the T-th strobed cycle. `s_stb_o` is low in cycle T+1.
- If ack and timeout fall in the same cycle, ack wins: no err, counter clears.

## Test plan
- Single master: m0 does a write burst (adr 0x70, 0x71, dat 0x74/0x08) then a read (s_dat_i=0xA5) → `grant`=01 one cycle after `cyc`; `s_*` mirror m0; `m0_ack_o` follows `s_ack_i` in the same cycle; `m0_dat_o`=0xA5; `grant`=00 one cycle after `cyc` drops.
- Contention: m1 asserts `cyc` while m0 owns for 6 cycles → `m1_ack_o`=0 throughout. m1 is granted exactly 2 cycles after m0 drops `cyc`; m0 traffic is never interleaved.
- Round-robin tie: both request from reset → m0 first, then m1, then m0. With `ROUND_ROBIN`=0 → m0 wins every tie.
- Watchdog: `TIMEOUT_CYCLES`=4, slave never acks → `m0_err_o` pulses in the 4th strobed cycle. `s_cyc_o`=0 next cycle. ABORT is held until m0 drops `cyc`; then m1 can be granted. With ack in the 4th cycle → no err.
- Reset mid-transfer: `rst_n`=0 while m1 owns with `stb` high → next edge: `grant`=00, all `s_*`, ack and err outputs 0. After release, a tie grants m0.

Source files
------------

// File: rtl/efb_wb_arbiter.sv
// efb_wb_arbiter: shares the single 8-bit EFB Wishbone slave between two
// masters. Ownership lasts for a whole cyc burst, so one master's command
// sequence is never interleaved with the other's. A per-transfer watchdog
// aborts a strobed transfer that never sees an ack.
//
// Handshake: a transfer is requested while the master holds cyc and stb high
// and completes in the cycle the slave raises ack (ack is forwarded to the
// owner combinationally). cyc framing owns the bus; stb gaps inside a burst
// keep ownership. Non-owners see ack/err low and simply stay pending.
module efb_wb_arbiter #(
  parameter int ROUND_ROBIN    = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       m0_cyc_i,
  input  logic       m0_stb_i,
  input  logic       m0_we_i,
  input  logic [7:0] m0_adr_i,
  input  logic [7:0] m0_dat_i,
  output logic [7:0] m0_dat_o,
  output logic       m0_ack_o,
  output logic       m0_err_o,
  input  logic       m1_cyc_i,
  input  logic       m1_stb_i,
  input  logic       m1_we_i,
  input  logic [7:0] m1_adr_i,
  input  logic [7:0] m1_dat_i,
  output logic [7:0] m1_dat_o,
  output logic       m1_ack_o,
  output logic       m1_err_o,
  output logic       s_cyc_o,
  output logic       s_stb_o,
  output logic       s_we_o,
  output logic [7:0] s_adr_o,
  output logic [7:0] s_dat_o,
  input  logic [7:0] s_dat_i,
  input  logic       s_ack_i,
  output logic [1:0] grant,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  // Watchdog fires when the counter reaches TIMEOUT_CYCLES-1, i.e. in the
  // T-th consecutive strobed cycle without ack. T=0 disables it.
  localparam logic        WD_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  localparam logic        RR_EN    = (ROUND_ROBIN != 0);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;          // 0 = m0, 1 = m1
  logic        last_owner_q, last_owner_d;
  logic [15:0] wd_cnt_q, wd_cnt_d;

  logic        own_cyc, own_stb, own_we;
  logic [7:0]  own_adr, own_dat;
  logic        stb_int;
  logic        own_ack, own_err;

  // Read data is broadcast; only the owner's ack qualifies it.
  assign m0_dat_o  = s_dat_i;
  assign m1_dat_o  = s_dat_i;
  assign dbg_state = state_q;

  // Grant is derived purely from registered state, so it only moves on edges.
  assign grant = (state_q == ST_IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);

  // Select the current owner's request lines.
  always_comb begin
    own_cyc = owner_q ? m1_cyc_i : m0_cyc_i;
    own_stb = owner_q ? m1_stb_i : m0_stb_i;
    own_we  = owner_q ? m1_we_i  : m0_we_i;
    own_adr = owner_q ? m1_adr_i : m0_adr_i;
    own_dat = owner_q ? m1_dat_i : m0_dat_i;
  end

  // State register, owner tracking and watchdog counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      wd_cnt_q     <= 16'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      wd_cnt_q     <= wd_cnt_d;
    end
  end

  // Next-state logic, slave-side mux and watchdog decision.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    s_cyc_o      = 1'b0;
    s_stb_o      = 1'b0;
    s_we_o       = 1'b0;
    s_adr_o      = 8'd0;
    s_dat_o      = 8'd0;
    stb_int      = 1'b0;
    own_ack      = 1'b0;
    own_err      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (m0_cyc_i || m1_cyc_i) begin
          state_d = ST_OWN;
          if (m0_cyc_i && m1_cyc_i) begin
            owner_d = RR_EN ? ~last_owner_q : 1'b0;
          end else begin
            owner_d = m1_cyc_i;
          end
        end
      end
      ST_OWN: begin
        stb_int = own_cyc && own_stb;
        s_cyc_o = own_cyc;
        s_stb_o = stb_int;
        s_we_o  = own_we;
        s_adr_o = own_adr;
        s_dat_o = own_dat;
        own_ack = s_ack_i;
        own_err = WD_EN && stb_int && !s_ack_i && (wd_cnt_q == WD_LIMIT);
        if (!own_cyc) begin
          state_d      = ST_IDLE;
          last_owner_d = owner_q;
        end else if (own_err) begin
          state_d = ST_ABORT;
        end
      end
      ST_ABORT: begin
        if (!own_cyc) begin
          state_d      = ST_IDLE;
          last_owner_d = owner_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counter runs only across consecutive strobed, unacked cycles of an owner.
  always_comb begin
    wd_cnt_d = 16'd0;
    if (state_q == ST_OWN && stb_int && !s_ack_i) begin
      wd_cnt_d = wd_cnt_q + 16'd1;
    end
  end

  // Route ack/err to the owner only.
  always_comb begin
    m0_ack_o = own_ack && !owner_q;
    m1_ack_o = own_ack &&  owner_q;
    m0_err_o = own_err && !owner_q;
    m1_err_o = own_err &&  owner_q;
  end

endmodule

// File: tb/tb_efb_wb_arbiter.sv
// Testbench for efb_wb_arbiter: a cycle-by-cycle vector table for the
// single-master burst and contention trace, plus hand-written sequences for
// tie-breaking, the watchdog and reset during a transfer. Two instances share
// the stimulus: round-robin and fixed priority, both with a 4-cycle timeout.
module tb_efb_wb_arbiter;

  logic       clk;
  logic       rst_n;
  logic       m0_cyc, m0_stb, m0_we;
  logic [7:0] m0_adr, m0_dat;
  logic       m1_cyc, m1_stb, m1_we;
  logic [7:0] m1_adr, m1_dat;
  logic [7:0] s_dat_i;
  logic       s_ack_i;

  // round-robin instance outputs
  logic [7:0] m0_rdat, m1_rdat;
  logic       m0_ack, m0_err, m1_ack, m1_err;
  logic       s_cyc, s_stb, s_we;
  logic [7:0] s_adr, s_dat;
  logic [1:0] grant, dbg_state;

  // fixed-priority instance outputs
  logic [7:0] fp_m0_rdat, fp_m1_rdat;
  logic       fp_m0_ack, fp_m0_err, fp_m1_ack, fp_m1_err;
  logic       fp_s_cyc, fp_s_stb, fp_s_we;
  logic [7:0] fp_s_adr, fp_s_dat;
  logic [1:0] fp_grant, fp_dbg_state;

  int checks = 0;
  int errors = 0;

  efb_wb_arbiter #(.ROUND_ROBIN(1), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(m0_rdat),
    .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(m1_rdat),
    .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
    .s_adr_o(s_adr), .s_dat_o(s_dat),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .grant(grant), .dbg_state(dbg_state)
  );

  efb_wb_arbiter #(.ROUND_ROBIN(0), .TIMEOUT_CYCLES(4)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(fp_m0_rdat),
    .m0_ack_o(fp_m0_ack), .m0_err_o(fp_m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(fp_m1_rdat),
    .m1_ack_o(fp_m1_ack), .m1_err_o(fp_m1_err),
    .s_cyc_o(fp_s_cyc), .s_stb_o(fp_s_stb), .s_we_o(fp_s_we),
    .s_adr_o(fp_s_adr), .s_dat_o(fp_s_dat),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .grant(fp_grant), .dbg_state(fp_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // global time limit
  initial begin
    #200000;
    $display("FAIL sim_timeout: got no finish, expected finish before limit");
    $fatal(1);
  end

  typedef struct {
    logic       m0_cyc, m0_stb, m0_we;
    logic [7:0] m0_adr, m0_dat;
    logic       m1_cyc, m1_stb, m1_we;
    logic [7:0] m1_adr, m1_dat;
    logic       s_ack;
    logic [7:0] s_dat;
    logic [1:0] e_grant;
    logic       e_cyc, e_stb, e_we;
    logic [7:0] e_adr, e_dat;
    logic       e_m0_ack, e_m1_ack;
  } vec_t;

  vec_t tbl[12];

  // scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  function automatic logic [18:0] sbus();
    return {s_cyc, s_stb, s_we, s_adr, s_dat};
  endfunction

  task automatic idle_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = 8'h00; m0_dat = 8'h00;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = 8'h00; m1_dat = 8'h00;
    s_ack_i = 0; s_dat_i = 8'h00;
  endtask

  initial begin
    // write burst 70/74, 71/08, read with A5, m1 contending, then m1 owns
    tbl[0]  = '{1,1,1,8'h70,8'h74, 0,0,0,8'h00,8'h00, 0,8'h00, 2'b00, 0,0,0,8'h00,8'h00, 0,0};
    tbl[1]  = '{1,1,1,8'h70,8'h74, 0,0,0,8'h00,8'h00, 1,8'h00, 2'b01, 1,1,1,8'h70,8'h74, 1,0};
    tbl[2]  = '{1,1,1,8'h71,8'h08, 0,0,0,8'h00,8'h00, 0,8'h00, 2'b01, 1,1,1,8'h71,8'h08, 0,0};
    tbl[3]  = '{1,1,1,8'h71,8'h08, 0,0,0,8'h00,8'h00, 1,8'h00, 2'b01, 1,1,1,8'h71,8'h08, 1,0};
    tbl[4]  = '{1,0,0,8'h72,8'h00, 1,1,1,8'h10,8'h55, 0,8'h00, 2'b01, 1,0,0,8'h72,8'h00, 0,0};
    tbl[5]  = '{1,1,0,8'h72,8'h00, 1,1,1,8'h10,8'h55, 0,8'hA5, 2'b01, 1,1,0,8'h72,8'h00, 0,0};
    tbl[6]  = '{1,1,0,8'h72,8'h00, 1,1,1,8'h10,8'h55, 1,8'hA5, 2'b01, 1,1,0,8'h72,8'h00, 1,0};
    tbl[7]  = '{0,0,0,8'h00,8'h00, 1,1,1,8'h10,8'h55, 0,8'h00, 2'b01, 0,0,0,8'h00,8'h00, 0,0};
    tbl[8]  = '{0,0,0,8'h00,8'h00, 1,1,1,8'h10,8'h55, 1,8'h3C, 2'b00, 0,0,0,8'h00,8'h00, 0,0};
    tbl[9]  = '{0,0,0,8'h00,8'h00, 1,1,1,8'h10,8'h55, 1,8'h3C, 2'b10, 1,1,1,8'h10,8'h55, 0,1};
    tbl[10] = '{0,0,0,8'h00,8'h00, 0,0,1,8'h10,8'h55, 0,8'h00, 2'b10, 0,0,1,8'h10,8'h55, 0,0};
    tbl[11] = '{0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,8'h00, 2'b00, 0,0,0,8'h00,8'h00, 0,0};

    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;

    // reset state
    mid();
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_sbus", 32'(sbus()), 32'h0);
    chk("reset_ackerr", {28'd0, m0_ack, m1_ack, m0_err, m1_err}, 32'h0);
    rst_n = 1;
    tick();

    // tie sequence: rr gives m0, m1, m0; fixed priority always m0
    m0_cyc = 1; m1_cyc = 1;
    mid();
    chk("tie_pre_grant", 32'(grant), 32'h0);
    tick();
    mid();
    chk("tie1_rr_grant", 32'(grant), 32'h1);
    chk("tie1_fp_grant", 32'(fp_grant), 32'h1);
    tick();
    m0_cyc = 0;
    tick();
    m0_cyc = 1;
    mid();
    chk("tie_dead_rr_grant", 32'(grant), 32'h0);
    chk("tie_dead_fp_grant", 32'(fp_grant), 32'h0);
    tick();
    mid();
    chk("tie2_rr_grant", 32'(grant), 32'h2);
    chk("tie2_fp_grant", 32'(fp_grant), 32'h1);
    m0_cyc = 0; m1_cyc = 0;
    tick();
    mid();
    m0_cyc = 1; m1_cyc = 1;
    tick();
    mid();
    chk("tie3_rr_grant", 32'(grant), 32'h1);
    chk("tie3_fp_grant", 32'(fp_grant), 32'h1);
    m0_cyc = 0; m1_cyc = 0;
    tick();
    tick();

    // table-driven burst / contention trace
    for (int i = 0; i < 12; i++) begin
      m0_cyc = tbl[i].m0_cyc; m0_stb = tbl[i].m0_stb; m0_we = tbl[i].m0_we;
      m0_adr = tbl[i].m0_adr; m0_dat = tbl[i].m0_dat;
      m1_cyc = tbl[i].m1_cyc; m1_stb = tbl[i].m1_stb; m1_we = tbl[i].m1_we;
      m1_adr = tbl[i].m1_adr; m1_dat = tbl[i].m1_dat;
      s_ack_i = tbl[i].s_ack; s_dat_i = tbl[i].s_dat;
      mid();
      chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(tbl[i].e_grant));
      chk($sformatf("vec%0d_sbus", i), 32'(sbus()),
          32'({tbl[i].e_cyc, tbl[i].e_stb, tbl[i].e_we, tbl[i].e_adr, tbl[i].e_dat}));
      chk($sformatf("vec%0d_acks", i), {30'd0, m0_ack, m1_ack},
          {30'd0, tbl[i].e_m0_ack, tbl[i].e_m1_ack});
      chk($sformatf("vec%0d_errs", i), {30'd0, m0_err, m1_err}, 32'h0);
      chk($sformatf("vec%0d_rdat", i), {16'd0, m0_rdat, m1_rdat}, {16'd0, tbl[i].s_dat, tbl[i].s_dat});
      tick();
    end
    idle_inputs();
    tick();

    // watchdog: slave never acks, m1 waits behind m0
    m0_cyc = 1; m0_stb = 1; m0_adr = 8'h33;
    m1_cyc = 1; m1_stb = 1;
    tick();
    for (int i = 1; i <= 4; i++) begin
      mid();
      chk($sformatf("wd_err_c%0d", i), 32'(m0_err), 32'(i == 4));
      chk($sformatf("wd_stb_c%0d", i), 32'(s_stb), 32'h1);
      chk($sformatf("wd_m1err_c%0d", i), 32'(m1_err), 32'h0);
      tick();
    end
    mid();
    chk("abort_sbus", 32'(sbus()), 32'h0);
    chk("abort_err", 32'(m0_err), 32'h0);
    chk("abort_grant", 32'(grant), 32'h1);
    tick();
    mid();
    chk("abort_hold_grant", 32'(grant), 32'h1);
    m0_cyc = 0; m0_stb = 0;
    tick();
    mid();
    chk("abort_release_grant", 32'(grant), 32'h0);
    tick();
    mid();
    chk("after_abort_m1_grant", 32'(grant), 32'h2);
    chk("after_abort_m1_cyc", 32'(s_cyc), 32'h1);
    m1_cyc = 0; m1_stb = 0;
    tick();
    tick();

    // ack in the 4th strobed cycle wins; counter then re-arms from zero
    m0_cyc = 1; m0_stb = 1;
    tick();
    for (int i = 1; i <= 8; i++) begin
      s_ack_i = (i == 4);
      mid();
      chk($sformatf("ackwin_err_c%0d", i), 32'(m0_err), 32'(i == 8));
      chk($sformatf("ackwin_ack_c%0d", i), 32'(m0_ack), 32'(i == 4));
      tick();
    end
    idle_inputs();
    tick();
    tick();

    // reset while m1 owns with stb high
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 8'h44; m1_dat = 8'h99;
    s_ack_i = 1;
    tick();
    mid();
    chk("pre_rst_grant", 32'(grant), 32'h2);
    chk("pre_rst_m1_ack", 32'(m1_ack), 32'h1);
    m0_cyc = 1;
    rst_n = 0;
    tick();
    mid();
    chk("rst_mid_grant", 32'(grant), 32'h0);
    chk("rst_mid_sbus", 32'(sbus()), 32'h0);
    chk("rst_mid_ackerr", {28'd0, m0_ack, m1_ack, m0_err, m1_err}, 32'h0);
    rst_n = 1;
    tick();
    mid();
    chk("post_rst_tie_grant", 32'(grant), 32'h1);
    chk("post_rst_tie_fp_grant", 32'(fp_grant), 32'h1);
    idle_inputs();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
